inst_queue_2w2r: RTL
====================

# inst_queue_2w2r

Parametrised dual-write/dual-read instruction queue between fetch and decode/issue. It accepts 0–2 fetched instructions per cycle and compacts them into a true circular FIFO with no holes. It presents the oldest 0–2 instructions to issue and retires 0, 1 or 2 per cycle under issue control. Flush discards all contents in one cycle; a sticky overflow flag catches protocol violations.

## Interface
Parameters:
- DEPTH, 16, entries; power of two, ≥4
- INST_W, 32, instruction width
- ADDR_W, 32, PC width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all entries (branch redirect / exception)
- in1_valid  in  1  fetch slot 1 valid
- in1_inst  in  INST_W  slot 1 instruction
- in1_pc  in  ADDR_W  slot 1 PC
- in2_valid  in  1  fetch slot 2 valid
- in2_inst  in  INST_W  slot 2 instruction
- in2_pc  in  ADDR_W  slot 2 PC
- in_ready  out  1  free entries ≥ 2
- pop_cnt  in  2  entries issue consumes this cycle (0/1/2; 3 treated as 2)
- stop_pop  in  1  forces effective pop count to 0
- out1_valid  out  1  head entry present
- out1_inst  out  INST_W  head instruction
- out1_pc  out  ADDR_W  head PC
- out2_valid  out  1  head+1 entry present
- out2_inst  out  INST_W  head+1 instruction
- out2_pc  out  ADDR_W  head+1 PC
- count  out  $clog2(DEPTH)+1  occupied entries
- overflow  out  1  sticky: push attempted with insufficient space

## Operation
- Storage: DEPTH entries of {inst, pc}. head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is a separate register.
- Push compaction. Valid inputs are written in slot order starting at tail, so 01→tail, 10→tail, 11→tail, tail+1. push_n = in1_valid + in2_valid. tail += push_n.
- Accepted push: push_n ≤ DEPTH − count + pop_eff. A push that fails this check is dropped entirely, state is unchanged, and overflow is set. Fetch is expected to honour in_ready, so this is an error case.
- Pop: pop_eff = stop_pop ? 0 : min(pop_cnt clamped to 2, count). head += pop_eff. Over-pop is clamped silently and is not an error.
- count_next = count + push_n − pop_eff, evaluated in the same cycle.
- Outputs are combinational from registered state:
  - out1_valid = (count ≥ 1); out2_valid = (count ≥ 2).
  - out*_inst and out*_pc read head and head+1, wrapped.
  - Data on an invalid output is don't-care.
- in_ready = (DEPTH − count) ≥ 2. It is registered-state based and does not include the current pop.
- flush has priority over push and pop. On flush, head, tail and count go to 0 and the push that cycle is discarded; overflow is unaffected. Array contents need not be cleared.
- rst: head, tail and count go to 0, and overflow goes to 0.

## Timing
- Write-to-read latency is 1 cycle: an entry pushed in cycle N is visible on out1/out2 in cycle N+1. There is no same-cycle bypass.
- Pop takes effect at the clock edge; the next entries are presented in the following cycle.
- Reset values: out1_valid=0, out2_valid=0, count=0, in_ready=1, overflow=0.
- Simultaneous push and pop in one cycle are both applied.
- Full boundary: with count=DEPTH and pop 2, a push of 2 is accepted; count stays DEPTH.
- Empty boundary: with count=0, a push of 2 gives count=2 and both outputs valid next cycle.
- Wrap: pointers roll over DEPTH−1→0 mid-pair. A pair written at tail=DEPTH−1 occupies entries DEPTH−1 and 0.
- rst or flush asserted mid-stream takes effect at the next edge; the queue is empty the following cycle.

## Structure
- In defines.vh:
  - default IQ_DEPTH, InstBus and InstAddrBus widths
  - encodings for pop count 0/1/2
- One natural sub-module, iq_ptr_ctrl. It holds head, tail, count, pop clamping, accept check and overflow, and outputs write enables and indices. The top level holds the storage array and the read muxes.

## Test plan
- Reset → out1_valid=0, out2_valid=0, count=0, in_ready=1, overflow=0. Then push {in1: 0x11111111 @0x1000, in2: 0x22222222 @0x1004} → next cycle out1=0x11111111/0x1000, out2=0x22222222/0x1004, count=2.
- Compaction: push slot2-only 0xAAAA0000, then slot1-only 0xBBBB0000 → out1=0xAAAA0000, out2=0xBBBB0000, count=2.
- Fill to DEPTH=16 with pop_cnt=0 → in_ready drops at count=15. Push 2 at count=15 with pop 0 → dropped, overflow=1, count stays 15.
- Steady state at count=16: push 2 with pop 2 each cycle for 20 cycles → count stays 16, PCs stay in order across wrap, overflow stays 0.
- Pop clamping: count=1 with pop_cnt=2 → count=0 next cycle. stop_pop=1 with pop_cnt=2 at count=4 → count=4.
- Flush at count=9 with a simultaneous push of 2 and pop of 1 → next cycle count=0, both outputs invalid. A following push is read back correctly starting at index 0.

Source files
------------

// File: rtl/inst_queue_2w2r_pkg.sv
// Shared definitions for the dual-write/dual-read instruction queue.
// Default sizes, pop-count encodings and the pop clamp helper.
package inst_queue_2w2r_pkg;

    localparam int IQ_DEPTH        = 16;
    localparam int INST_BUS_W      = 32;
    localparam int INST_ADDR_BUS_W = 32;

    typedef enum logic [1:0] {
        POP_NONE = 2'd0,
        POP_ONE  = 2'd1,
        POP_TWO  = 2'd2
    } pop_e;

    // Issue never retires more than two per cycle; 3 behaves as 2.
    function automatic logic [1:0] clamp_pop(input logic [1:0] p);
        logic [1:0] r;
        r = p;
        if (p == 2'd3) begin
            r = POP_TWO;
        end
        return r;
    endfunction

endpackage

// File: rtl/iq_ptr_ctrl.sv
// Pointer/occupancy control for the instruction queue.
// Owns head, tail, count, accept check and the sticky overflow flag.
module iq_ptr_ctrl
    import inst_queue_2w2r_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in1_valid,
    input  logic                       in2_valid,
    input  logic [1:0]                 pop_cnt,
    input  logic                       stop_pop,
    output logic                       we0,
    output logic                       we1,
    output logic                       sel0,
    output logic [$clog2(DEPTH)-1:0]   idx0,
    output logic [$clog2(DEPTH)-1:0]   idx1,
    output logic [$clog2(DEPTH)-1:0]   rd_idx0,
    output logic [$clog2(DEPTH)-1:0]   rd_idx1,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       in_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [1:0]       push_n;
    logic [1:0]       push_acc;
    logic [1:0]       pop_req;
    logic [1:0]       pop_eff;
    logic [CNT_W:0]   room;
    logic             accept;
    logic [CNT_W-1:0] count_nxt;

    // Pop clamping, space check and write steering for this cycle.
    always_comb begin
        push_n  = {1'b0, in1_valid} + {1'b0, in2_valid};
        pop_req = stop_pop ? POP_NONE : clamp_pop(pop_cnt);
        pop_eff = pop_req;
        if ({{(CNT_W-2){1'b0}}, pop_req} > count) begin
            pop_eff = count[1:0];
        end
        room = (CNT_W+1)'(DEPTH) - {1'b0, count}
             + {{(CNT_W-1){1'b0}}, pop_eff};
        accept = {{(CNT_W-1){1'b0}}, push_n} <= room;
        push_acc = accept ? push_n : 2'd0;
        count_nxt = count
                  + {{(CNT_W-2){1'b0}}, push_acc}
                  - {{(CNT_W-2){1'b0}}, pop_eff};
        we0 = !flush && accept && (push_n != 2'd0);
        we1 = !flush && accept && (push_n == 2'd2);
        sel0 = !in1_valid;
        idx0 = tail;
        idx1 = tail + PTR_W'(1);
        rd_idx0 = head;
        rd_idx1 = head + PTR_W'(1);
        in_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
    end

    // Pointer and count update; a dropped push still lets issue retire.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + {{(PTR_W-2){1'b0}}, pop_eff};
            tail  <= tail + {{(PTR_W-2){1'b0}}, push_acc};
            count <= count_nxt;
        end
    end

    // Sticky flag for a push that fetch sent without enough room.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (!flush && !accept) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/inst_queue_2w2r.sv
// Dual-write/dual-read instruction queue between fetch and issue.
// Holds the entry storage and head/head+1 read muxes.
module inst_queue_2w2r
    import inst_queue_2w2r_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int INST_W = INST_BUS_W,
    parameter int ADDR_W = INST_ADDR_BUS_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in1_valid,
    input  logic [INST_W-1:0]        in1_inst,
    input  logic [ADDR_W-1:0]        in1_pc,
    input  logic                     in2_valid,
    input  logic [INST_W-1:0]        in2_inst,
    input  logic [ADDR_W-1:0]        in2_pc,
    output logic                     in_ready,
    input  logic [1:0]               pop_cnt,
    input  logic                     stop_pop,
    output logic                     out1_valid,
    output logic [INST_W-1:0]        out1_inst,
    output logic [ADDR_W-1:0]        out1_pc,
    output logic                     out2_valid,
    output logic [INST_W-1:0]        out2_inst,
    output logic [ADDR_W-1:0]        out2_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic             we0;
    logic             we1;
    logic             sel0;
    logic [PTR_W-1:0] idx0;
    logic [PTR_W-1:0] idx1;
    logic [PTR_W-1:0] rd_idx0;
    logic [PTR_W-1:0] rd_idx1;

    iq_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in1_valid (in1_valid),
        .in2_valid (in2_valid),
        .pop_cnt   (pop_cnt),
        .stop_pop  (stop_pop),
        .we0       (we0),
        .we1       (we1),
        .sel0      (sel0),
        .idx0      (idx0),
        .idx1      (idx1),
        .rd_idx0   (rd_idx0),
        .rd_idx1   (rd_idx1),
        .count     (count),
        .overflow  (overflow),
        .in_ready  (in_ready)
    );

    // Compacted write: first valid slot lands at tail, slot 2 of a pair at tail+1.
    always_ff @(posedge clk) begin
        if (we0) begin
            inst_mem[idx0] <= sel0 ? in2_inst : in1_inst;
            pc_mem[idx0]   <= sel0 ? in2_pc   : in1_pc;
        end
        if (we1) begin
            inst_mem[idx1] <= in2_inst;
            pc_mem[idx1]   <= in2_pc;
        end
    end

    // Oldest two entries presented straight from storage.
    always_comb begin
        out1_valid = count >= CNT_W'(1);
        out2_valid = count >= CNT_W'(2);
        out1_inst  = inst_mem[rd_idx0];
        out1_pc    = pc_mem[rd_idx0];
        out2_inst  = inst_mem[rd_idx1];
        out2_pc    = pc_mem[rd_idx1];
    end

endmodule
